// File: rtl/task_fence_unit_if.sv
// Scheduler-to-dispatch request channel for task_fence_unit.
// The scheduler raises req_valid with a stable header and holds it until it sees
// req_ack high for one cycle; that cycle consumes the header, and the scheduler
// may present the next header from the following cycle on.
interface task_fence_unit_if #(
    parameter int CORES_COUNT = 16
);
    logic                   req_valid;
    logic [1:0]             req_fence;
    logic [CORES_COUNT-1:0] req_mask;
    logic                   req_ack;

    modport master (
        output req_valid,
        output req_fence,
        output req_mask,
        input  req_ack
    );

    modport slave (
        input  req_valid,
        input  req_fence,
        input  req_mask,
        output req_ack
    );
endinterface

// File: rtl/task_fence_unit.sv
// Fence-aware dispatch gate: starts cores for one task header at a time and tracks busy cores.
// Optional fence watchdog enabled by defining TS_FENCE_TIMEOUT_EN.
module task_fence_unit #(
    parameter int CORES_COUNT    = 16,
    parameter int STALL_W        = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   reset,
    task_fence_unit_if.slave       req,
    input  logic [CORES_COUNT-1:0] Ready,
    output logic [CORES_COUNT-1:0] Start,
    output logic [CORES_COUNT-1:0] busy_mask,
    output logic                   fence_err,
    output logic [STALL_W-1:0]     stall_cnt,
    output logic                   timeout,
    output logic [1:0]             fsm_state
);

    localparam logic [1:0] FENCE_NO  = 2'b00;
    localparam logic [1:0] FENCE_ACQ = 2'b01;
    localparam logic [1:0] FENCE_REL = 2'b10;
    localparam logic [1:0] FENCE_RSV = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_ACQ = 2'd1,
        S_ISSUE    = 2'd2,
        S_WAIT_REL = 2'd3
    } state_t;

    state_t                 state;
    state_t                 next_state;
    logic [CORES_COUNT-1:0] hdr_mask;
    logic [1:0]             hdr_fence;
    logic [CORES_COUNT-1:0] rel_mask;
    logic [CORES_COUNT-1:0] start_d;
    logic                   fence_ok;
    logic                   accept;
    logic                   hdr_load;
    logic                   tmo_hit;
    logic                   ack;

    assign fsm_state   = state;
    assign req.req_ack = ack;

    always_comb begin
        fence_ok = 1'b0;
        case (req.req_fence)
            FENCE_NO:  fence_ok = ((req.req_mask & busy_mask) == '0);
            FENCE_ACQ: fence_ok = (busy_mask == '0);
            FENCE_REL: fence_ok = ((req.req_mask & busy_mask) == '0);
            default:   fence_ok = 1'b1;
        endcase
    end

    assign accept = req.req_valid && fence_ok &&
                    ((state == S_IDLE) || (state == S_WAIT_ACQ));

    // Header is captured on the way into ISSUE, including a watchdog-forced ACQ issue.
    assign hdr_load = (next_state == S_ISSUE) && (state != S_ISSUE);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    next_state = S_ISSUE;
                end else if (req.req_valid && (req.req_fence == FENCE_ACQ)) begin
                    next_state = S_WAIT_ACQ;
                end
            end
            S_WAIT_ACQ: begin
                if (accept || tmo_hit) begin
                    next_state = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if ((hdr_fence == FENCE_REL) && (hdr_mask != '0)) begin
                    next_state = S_WAIT_REL;
                end else begin
                    next_state = S_IDLE;
                end
            end
            S_WAIT_REL: begin
                if (((busy_mask & rel_mask) == '0) || tmo_hit) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        ack   = 1'b0;
        Start = '0;
        if (state == S_ISSUE) begin
            ack = 1'b1;
            if (hdr_fence != FENCE_RSV) begin
                Start = hdr_mask;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hdr_mask  <= '0;
            hdr_fence <= FENCE_NO;
        end else if (hdr_load) begin
            hdr_mask  <= req.req_mask;
            hdr_fence <= req.req_fence;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rel_mask  <= '0;
            fence_err <= 1'b0;
        end else if (state == S_ISSUE) begin
            if ((hdr_fence == FENCE_REL) && (hdr_mask != '0)) begin
                rel_mask <= hdr_mask;
            end
            if (hdr_fence == FENCE_RSV) begin
                fence_err <= 1'b1;
            end
        end
    end

    // A core's Ready is ignored in its Start cycle and the cycle after, since
    // the core only drops Ready one cycle after seeing Start.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy_mask <= '0;
            start_d   <= '0;
        end else begin
            start_d <= Start;
            if (tmo_hit) begin
                busy_mask <= '0;
            end else begin
                busy_mask <= Start | (busy_mask & ~(Ready & ~start_d));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (req.req_valid && (state != S_ISSUE) && !accept &&
                     (stall_cnt != {STALL_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

`ifdef TS_FENCE_TIMEOUT_EN
    localparam int WCNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WCNT_W-1:0] wait_cnt;
    logic              in_wait;

    assign in_wait = (state == S_WAIT_ACQ) || (state == S_WAIT_REL);
    assign tmo_hit = in_wait && (wait_cnt == WCNT_W'(TIMEOUT_CYCLES - 1));

    // Counts consecutive cycles spent in one wait state; cleared on exit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (in_wait && (next_state == state)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            timeout <= 1'b0;
        end else if (tmo_hit) begin
            timeout <= 1'b1;
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_task_fence_unit.sv
// Directed bench for task_fence_unit: single-dispatch vector table plus fence corner sequences.
module tb_task_fence_unit;
    localparam int CORES = 16;
    localparam int SW    = 4;
    localparam int TMO   = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [CORES-1:0] Ready;
    logic [CORES-1:0] Start;
    logic [CORES-1:0] busy_mask;
    logic             fence_err;
    logic [SW-1:0]    stall_cnt;
    logic             timeout;
    logic [1:0]       fsm_state;

    task_fence_unit_if #(.CORES_COUNT(CORES)) req_if();

    task_fence_unit #(
        .CORES_COUNT    (CORES),
        .STALL_W        (SW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req_if),
        .Ready     (Ready),
        .Start     (Start),
        .busy_mask (busy_mask),
        .fence_err (fence_err),
        .stall_cnt (stall_cnt),
        .timeout   (timeout),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [1:0] fence;
        logic [15:0] mask;
        logic [15:0] exp_start;
        logic       exp_err;
        logic [1:0] exp_state;
    } vec_t;

    vec_t vecs[7];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset            = 1'b0;
        req_if.req_valid = 1'b0;
        req_if.req_fence = 2'b00;
        req_if.req_mask  = '0;
        Ready            = '1;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic present(input logic [1:0] f, input logic [15:0] m);
        req_if.req_valid = 1'b1;
        req_if.req_fence = f;
        req_if.req_mask  = m;
    endtask

    // Present a header to an idle unit; the target cores drop Ready after Start.
    task automatic dispatch(input logic [1:0] f, input logic [15:0] m,
                            output logic ack_seen, output logic [15:0] start_seen);
        present(f, m);
        step();
        ack_seen   = req_if.req_ack;
        start_seen = Start;
        step();
        req_if.req_valid = 1'b0;
        Ready = Ready & ~start_seen;
    endtask

    task automatic wait_ack(input int budget, output int cycles);
        cycles = 0;
        while (!req_if.req_ack && cycles < budget) begin
            step();
            cycles++;
        end
        if (!req_if.req_ack) begin
            chk("wait_ack budget", 32'(cycles), 32'(budget + 1));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ack;
        logic [15:0] st;
        int          cyc;

        vecs[0] = '{"no_000f",   2'b00, 16'h000F, 16'h000F, 1'b0, 2'd0};
        vecs[1] = '{"acq_0001",  2'b01, 16'h0001, 16'h0001, 1'b0, 2'd0};
        vecs[2] = '{"rel_0030",  2'b10, 16'h0030, 16'h0030, 1'b0, 2'd3};
        vecs[3] = '{"rsv_00ff",  2'b11, 16'h00FF, 16'h0000, 1'b1, 2'd0};
        vecs[4] = '{"no_empty",  2'b00, 16'h0000, 16'h0000, 1'b0, 2'd0};
        vecs[5] = '{"rel_empty", 2'b10, 16'h0000, 16'h0000, 1'b0, 2'd0};
        vecs[6] = '{"no_ffff",   2'b00, 16'hFFFF, 16'hFFFF, 1'b0, 2'd0};

        // Reset state
        do_reset();
        chk("rst state", 32'(fsm_state), 32'd0);
        chk("rst start", 32'(Start), 32'd0);
        chk("rst ack", 32'(req_if.req_ack), 32'd0);
        chk("rst busy", 32'(busy_mask), 32'd0);
        chk("rst err", 32'(fence_err), 32'd0);
        chk("rst stall", 32'(stall_cnt), 32'd0);
        chk("rst timeout", 32'(timeout), 32'd0);

        // Single dispatch from a clean unit: ack and Start one cycle after presenting
        for (int i = 0; i < 7; i++) begin
            do_reset();
            dispatch(vecs[i].fence, vecs[i].mask, ack, st);
            chk({vecs[i].name, " ack"}, 32'(ack), 32'd1);
            chk({vecs[i].name, " start"}, 32'(st), 32'(vecs[i].exp_start));
            chk({vecs[i].name, " busy"}, 32'(busy_mask), 32'(vecs[i].exp_start));
            chk({vecs[i].name, " err"}, 32'(fence_err), 32'(vecs[i].exp_err));
            chk({vecs[i].name, " state"}, 32'(fsm_state), 32'(vecs[i].exp_state));
        end

        // T2: overlap stalls until core1 completes
        do_reset();
        dispatch(2'b00, 16'h0003, ack, st);
        present(2'b00, 16'h0006);
        step(); step(); step();
        chk("t2 held ack", 32'(req_if.req_ack), 32'd0);
        chk("t2 held stall", 32'(stall_cnt), 32'd3);
        Ready = 16'hFFFE;
        step();
        chk("t2 busy after ready", 32'(busy_mask), 32'h0001);
        step();
        chk("t2 ack", 32'(req_if.req_ack), 32'd1);
        chk("t2 start", 32'(Start), 32'h0006);
        chk("t2 stall", 32'(stall_cnt), 32'd4);
        step();
        req_if.req_valid = 1'b0;
        Ready = ~16'h0007;
        chk("t2 busy", 32'(busy_mask), 32'h0007);

        // T3: acquire waits for every core to drain
        do_reset();
        dispatch(2'b00, 16'h0100, ack, st);
        present(2'b01, 16'h0001);
        step();
        chk("t3 wait_acq", 32'(fsm_state), 32'd1);
        step(); step();
        chk("t3 stall", 32'(stall_cnt), 32'd3);
        chk("t3 held ack", 32'(req_if.req_ack), 32'd0);
        Ready = '1;
        step();
        chk("t3 still waiting", 32'(fsm_state), 32'd1);
        step();
        chk("t3 ack", 32'(req_if.req_ack), 32'd1);
        chk("t3 start", 32'(Start), 32'h0001);
        chk("t3 stall final", 32'(stall_cnt), 32'd4);
        step();
        req_if.req_valid = 1'b0;

        // T4: release holds the next header until cores 4 and 5 finish
        do_reset();
        dispatch(2'b10, 16'h0030, ack, st);
        present(2'b00, 16'h0001);
        step(); step(); step();
        chk("t4 wait_rel", 32'(fsm_state), 32'd3);
        chk("t4 held ack", 32'(req_if.req_ack), 32'd0);
        Ready = ~16'h0020;
        step(); step();
        chk("t4 one core left", 32'(fsm_state), 32'd3);
        chk("t4 busy", 32'(busy_mask), 32'h0020);
        Ready = '1;
        wait_ack(10, cyc);
        chk("t4 release latency", 32'(cyc), 32'd3);
        chk("t4 start", 32'(Start), 32'h0001);
        chk("t4 stall", 32'(stall_cnt), 32'd7);
        step();
        req_if.req_valid = 1'b0;

        // T5: reserved fence is sticky; reset mid-WAIT_REL clears everything
        do_reset();
        dispatch(2'b11, 16'h00FF, ack, st);
        chk("t5 rsv ack", 32'(ack), 32'd1);
        chk("t5 rsv start", 32'(st), 32'd0);
        dispatch(2'b00, 16'h0001, ack, st);
        chk("t5 err sticky", 32'(fence_err), 32'd1);
        dispatch(2'b10, 16'h0030, ack, st);
        chk("t5 in wait_rel", 32'(fsm_state), 32'd3);
        reset = 1'b0;
        step();
        chk("t5 rst state", 32'(fsm_state), 32'd0);
        chk("t5 rst busy", 32'(busy_mask), 32'd0);
        chk("t5 rst err", 32'(fence_err), 32'd0);
        chk("t5 rst start", 32'(Start), 32'd0);
        reset = 1'b1;
        Ready = '1;

        // Stall counter saturates at all-ones
        do_reset();
        dispatch(2'b00, 16'h0001, ack, st);
        present(2'b00, 16'h0001);
        for (int i = 0; i < 20; i++) step();
        chk("sat stall", 32'(stall_cnt), 32'hF);
        chk("sat no ack", 32'(req_if.req_ack), 32'd0);

`ifdef TS_FENCE_TIMEOUT_EN
        // T6: watchdog forces an ACQ issue after TMO wait cycles
        do_reset();
        dispatch(2'b00, 16'h0100, ack, st);
        present(2'b01, 16'h0001);
        step();
        for (int i = 0; i < TMO - 1; i++) step();
        chk("t6 before timeout", 32'(timeout), 32'd0);
        chk("t6 still waiting", 32'(fsm_state), 32'd1);
        step();
        chk("t6 timeout", 32'(timeout), 32'd1);
        chk("t6 ack", 32'(req_if.req_ack), 32'd1);
        chk("t6 start", 32'(Start), 32'h0001);
        step();
        req_if.req_valid = 1'b0;
`else
        chk("timeout tied low", 32'(timeout), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
